// File: rtl/regfile_nxm.sv
// Parametrised 2R/1W register file with registered reads and a hardware clear sequencer.
// Optional write-first forwarding to the read ports: define REGFILE_BYPASS_EN.
module regfile_nxm #(
  parameter int WIDTH  = 16,
  parameter int DEPTH  = 8,
  parameter int ADDR_W = 3
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              write,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [WIDTH-1:0]  wr_data,
  input  logic [ADDR_W-1:0] rd_addr_a,
  output logic [WIDTH-1:0]  rd_data_a,
  input  logic [ADDR_W-1:0] rd_addr_b,
  output logic [WIDTH-1:0]  rd_data_b,
  input  logic              clr_start,
  output logic              busy,
  output logic              clr_done
);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } state_t;

  localparam logic [ADDR_W:0]   DEPTH_C    = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST_IDX_C = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W-1:0] IDX_ONE_C  = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] IDX_ZERO_C = {ADDR_W{1'b0}};
  localparam logic [WIDTH-1:0]  DATA_ZERO_C = {WIDTH{1'b0}};

  state_t            state_r;
  state_t            state_nxt_s;
  logic [ADDR_W-1:0] clr_idx_r;
  logic [ADDR_W-1:0] clr_idx_nxt_s;
  logic              clr_last_s;
  logic              busy_r;
  logic              clr_done_r;

  logic [WIDTH-1:0]  mem_r [DEPTH];

  logic              we_s;
  logic [ADDR_W-1:0] wa_s;
  logic [WIDTH-1:0]  wd_s;

  logic              byp_a_s;
  logic              byp_b_s;
  logic [WIDTH-1:0]  rd_a_s;
  logic [WIDTH-1:0]  rd_b_s;
  logic [WIDTH-1:0]  rd_data_a_r;
  logic [WIDTH-1:0]  rd_data_b_r;

  // Next-state logic and selection of the single effective write (external or clear)
  always_comb begin
    state_nxt_s   = state_r;
    clr_idx_nxt_s = clr_idx_r;
    clr_last_s    = 1'b0;
    we_s          = 1'b0;
    wa_s          = wr_addr;
    wd_s          = wr_data;
    case (state_r)
      ST_IDLE: begin
        we_s          = write && ({1'b0, wr_addr} < DEPTH_C);
        clr_idx_nxt_s = IDX_ZERO_C;
        if (clr_start) begin
          state_nxt_s = ST_CLEAR;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_CLEAR: begin
        we_s = 1'b1;
        wa_s = clr_idx_r;
        wd_s = DATA_ZERO_C;
        if (clr_idx_r == LAST_IDX_C) begin
          clr_last_s    = 1'b1;
          state_nxt_s   = ST_IDLE;
          clr_idx_nxt_s = IDX_ZERO_C;
        end else begin
          state_nxt_s   = ST_CLEAR;
          clr_idx_nxt_s = clr_idx_r + IDX_ONE_C;
        end
      end
      default: begin
        state_nxt_s   = ST_IDLE;
        clr_idx_nxt_s = IDX_ZERO_C;
      end
    endcase
  end

`ifdef REGFILE_BYPASS_EN
  assign byp_a_s = we_s && (wa_s == rd_addr_a);
  assign byp_b_s = we_s && (wa_s == rd_addr_b);
`else
  assign byp_a_s = 1'b0;
  assign byp_b_s = 1'b0;
`endif

  // Read-port muxing: forwarded write data, stored entry, or zero for out-of-range addresses
  always_comb begin
    rd_a_s = DATA_ZERO_C;
    rd_b_s = DATA_ZERO_C;
    if (byp_a_s) begin
      rd_a_s = wd_s;
    end else if ({1'b0, rd_addr_a} < DEPTH_C) begin
      rd_a_s = mem_r[rd_addr_a];
    end else begin
      rd_a_s = DATA_ZERO_C;
    end
    if (byp_b_s) begin
      rd_b_s = wd_s;
    end else if ({1'b0, rd_addr_b} < DEPTH_C) begin
      rd_b_s = mem_r[rd_addr_b];
    end else begin
      rd_b_s = DATA_ZERO_C;
    end
  end

  // Storage array; we_s is only ever asserted for in-range addresses
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= DATA_ZERO_C;
      end
    end else if (we_s) begin
      mem_r[wa_s] <= wd_s;
    end
  end

  // FSM, clear index and registered status/read outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r     <= ST_IDLE;
      clr_idx_r   <= IDX_ZERO_C;
      busy_r      <= 1'b0;
      clr_done_r  <= 1'b0;
      rd_data_a_r <= DATA_ZERO_C;
      rd_data_b_r <= DATA_ZERO_C;
    end else begin
      state_r     <= state_nxt_s;
      clr_idx_r   <= clr_idx_nxt_s;
      busy_r      <= (state_nxt_s == ST_CLEAR);
      clr_done_r  <= clr_last_s;
      rd_data_a_r <= rd_a_s;
      rd_data_b_r <= rd_b_s;
    end
  end

  assign rd_data_a = rd_data_a_r;
  assign rd_data_b = rd_data_b_r;
  assign busy      = busy_r;
  assign clr_done  = clr_done_r;

endmodule
